ps2_keycode: RTL and testbench
==============================

PS2_KEYCODE -- requirements
Module: ps2_keycode

Interface
Parameters:
REQ-001 SHALL have parameter TIMEOUT_CYC, default 10000, the number of Clk cycles without a ps2_clk falling edge before a partial frame is abandoned (200 us at 50 MHz).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the flip-flop depth of the input synchronizer on ps2_clk and ps2_data (minimum 2).

Ports (name, direction, width, meaning):
REQ-003 Clk, input, 1: the system clock (50 MHz); every flop SHALL be clocked by its rising edge.
REQ-004 Reset_n, input, 1: asynchronous, active-low reset.
REQ-005 ps2_clk, input, 1: PS/2 device clock, asynchronous to Clk.
REQ-006 ps2_data, input, 1: PS/2 device data, asynchronous to Clk.
REQ-007 keycode, output, 8: USB HID usage code of the mapped key most recently pressed and still held; 0x00 when no such key is held.
REQ-008 keycode_strobe, output, 1: 1-cycle pulse whenever keycode changes value.
REQ-009 scan_byte, output, 8: last correctly received raw set-2 byte.
REQ-010 scan_valid, output, 1: 1-cycle pulse when scan_byte is updated.
REQ-011 frame_err, output, 1: 1-cycle pulse on any start, parity or stop error, or on a timeout.

Function
REQ-012 SHALL synchronize ps2_clk and ps2_data through SYNC_STAGES flops, and SHALL detect a falling edge as a synchronized 1 followed by a synchronized 0.
REQ-013 The receive FSM SHALL have the states IDLE, DATA, PARITY and STOP, and SHALL sample ps2_data only on a detected falling edge.
REQ-014 IDLE: start bit 0 -> DATA with the bit count cleared; start bit 1 -> stay in IDLE and pulse frame_err.
REQ-015 DATA: SHALL shift in 8 bits LSB first, then go to PARITY.
REQ-016 PARITY: SHALL check odd parity over the 8 data bits plus the parity bit, latch the result, then go to STOP.
REQ-017 STOP: stop bit 1 with good parity SHALL produce scan_valid in the cycle after the edge; a bad stop or bad parity SHALL produce frame_err instead; in all cases the FSM returns to IDLE.
REQ-018 A timeout counter SHALL clear on every falling edge and count while the FSM is not in IDLE.
REQ-019 When the timeout counter reaches TIMEOUT_CYC, the FSM SHALL return to IDLE, pulse frame_err, and discard the partial byte.
REQ-020 An edge detected in the same cycle the counter reaches TIMEOUT_CYC SHALL win: the edge is processed and no timeout occurs.
REQ-021 Decoder flags break_pend and ext_pend SHALL be updated on scan_valid: byte 0xF0 sets break_pend, byte 0xE0 sets ext_pend, and any other byte is a key code that is decoded and then clears both flags.
REQ-022 Key map, non-extended: 0x5A->0x28, 0x1D->0x1A, 0x1C->0x04, 0x1B->0x16, 0x23->0x07, 0x29->0x2C, 0x76->0x29.
REQ-023 Key map, extended: 0x75->0x52, 0x72->0x51, 0x6B->0x50, 0x74->0x4F, 0x5A->0x28.
REQ-024 Any other code, including 0xE1 and 0xAA, is unmapped: keycode SHALL NOT change, but both flags SHALL still clear.
REQ-025 Make of a mapped key SHALL set keycode to its HID code, overriding any key already held.
REQ-026 Break of a mapped key SHALL set keycode to 0x00 only if keycode equals that key's HID code; otherwise keycode SHALL NOT change.
REQ-027 keycode SHALL update in the cycle after scan_valid, i.e. 2 Clk cycles after the stop-bit edge is detected, and keycode_strobe SHALL fire in that same cycle only if the value changed.
REQ-028 A repeated make of the held key (typematic repeat) SHALL produce no keycode_strobe.
REQ-029 A frame_err SHALL NOT alter keycode, break_pend or ext_pend.

Reset
REQ-030 While Reset_n = 0, regardless of the clock: FSM = IDLE, bit and timeout counters = 0, flags = 0, keycode = 0x00, scan_byte = 0x00, and all pulse outputs = 0.
REQ-031 Reset asserted mid-frame SHALL discard the frame; the first frame after release SHALL decode normally.

Verification
REQ-032 Frame with byte 0x5A and good parity -> scan_byte = 0x5A, scan_valid pulse, keycode = 0x28 two cycles after the stop edge, keycode_strobe pulse.
REQ-033 Sequence E0 75, then E0 F0 75 -> keycode = 0x52, then 0x00, with two strobes.
REQ-034 Sequence 1D, then 1C, then F0 1D -> keycode 0x1A, then 0x04, then stays 0x04 with no third strobe.
REQ-035 Byte 0x1D sent with even parity -> frame_err pulse, no scan_valid, keycode unchanged.
REQ-036 Five bits sent, then the line idles for TIMEOUT_CYC cycles -> frame_err pulse, FSM in IDLE, and a following 0x23 frame decodes to keycode = 0x07.
REQ-037 Reset_n asserted during bit 4 of a frame -> keycode = 0x00 immediately, and the next full 0x29 frame decodes to keycode = 0x2C.

Source files
------------

// File: rtl/ps2_keycode.sv
// PS/2 set-2 receiver with a small make/break decoder that tracks the most recently
// pressed mapped key as a USB HID usage code.
module ps2_keycode #(
  parameter int TIMEOUT_CYC = 10000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       keycode_strobe,
  output logic [7:0] scan_byte,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  // Returns {mapped, hid_code}; unmapped codes return 9'h000.
  function automatic logic [8:0] map_key(input logic ext, input logic [7:0] code);
    logic [8:0] r;
    r = 9'h000;
    if (ext) begin
      case (code)
        8'h75:   r = {1'b1, 8'h52};
        8'h72:   r = {1'b1, 8'h51};
        8'h6B:   r = {1'b1, 8'h50};
        8'h74:   r = {1'b1, 8'h4F};
        8'h5A:   r = {1'b1, 8'h28};
        default: r = 9'h000;
      endcase
    end else begin
      case (code)
        8'h5A:   r = {1'b1, 8'h28};
        8'h1D:   r = {1'b1, 8'h1A};
        8'h1C:   r = {1'b1, 8'h04};
        8'h1B:   r = {1'b1, 8'h16};
        8'h23:   r = {1'b1, 8'h07};
        8'h29:   r = {1'b1, 8'h2C};
        8'h76:   r = {1'b1, 8'h29};
        default: r = 9'h000;
      endcase
    end
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   data_bit;

  state_t         state;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift;
  logic           par_ok;
  logic [TW-1:0]  tcnt;

  logic           break_pend;
  logic           ext_pend;
  logic [8:0]     lookup;

  assign fall     = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign data_bit = data_sync[SYNC_STAGES-1];
  assign lookup   = map_key(ext_pend, scan_byte);

  // Input synchronizers; idle PS/2 lines are high, so reset to 1 to avoid a false edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_sync  <= {SYNC_STAGES{1'b1}};
      data_sync <= {SYNC_STAGES{1'b1}};
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  // Receive FSM with inactivity timeout; an edge always takes priority over expiry.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      par_ok     <= 1'b0;
      tcnt       <= '0;
      scan_byte  <= 8'h00;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        case (state)
          IDLE: begin
            if (!data_bit) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          DATA: begin
            shift   <= {data_bit, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par_ok <= odd_parity_ok(shift, data_bit);
            state  <= STOP;
          end
          STOP: begin
            if (data_bit && par_ok) begin
              scan_byte  <= shift;
              scan_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (tcnt == TLIM) begin
          state     <= IDLE;
          bit_cnt   <= 3'd0;
          tcnt      <= '0;
          frame_err <= 1'b1;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

  // Make/break decoder driven by each good byte.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      break_pend     <= 1'b0;
      ext_pend       <= 1'b0;
      keycode        <= 8'h00;
      keycode_strobe <= 1'b0;
    end else begin
      keycode_strobe <= 1'b0;
      if (scan_valid) begin
        if (scan_byte == 8'hF0) begin
          break_pend <= 1'b1;
        end else if (scan_byte == 8'hE0) begin
          ext_pend <= 1'b1;
        end else begin
          break_pend <= 1'b0;
          ext_pend   <= 1'b0;
          if (lookup[8]) begin
            if (break_pend) begin
              if (keycode == lookup[7:0]) begin
                keycode        <= 8'h00;
                keycode_strobe <= 1'b1;
              end
            end else if (keycode != lookup[7:0]) begin
              keycode        <= lookup[7:0];
              keycode_strobe <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode.sv
// Directed PS/2 frames against a key-event model of the decoder, with per-cycle output checks.
module tb_ps2_keycode;

  localparam int TOUT = 200;
  localparam int HALF = 20;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode;
  logic       keycode_strobe;
  logic [7:0] scan_byte;
  logic       scan_valid;
  logic       frame_err;

  ps2_keycode #(.TIMEOUT_CYC(TOUT), .SYNC_STAGES(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keycode(keycode), .keycode_strobe(keycode_strobe),
    .scan_byte(scan_byte), .scan_valid(scan_valid), .frame_err(frame_err)
  );

  always #10 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_sv = -100;
  int sv_cnt = 0, fe_cnt = 0, ks_cnt = 0;
  int exp_sv = 0, exp_fe = 0, exp_ks = 0;
  bit settled = 1'b0;
  logic [7:0] prev_kc = 8'h00;
  logic [7:0] exp_q[$];

  // Model state: what the decoder must hold after the bytes seen so far.
  logic [7:0] map_n [logic [7:0]];
  logic [7:0] map_e [logic [7:0]];
  logic [7:0] m_kc = 8'h00;
  logic [7:0] m_last = 8'h00;
  bit m_brk = 1'b0, m_ext = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] nk;
    bit mapped;
    logic [7:0] hid;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      mapped = m_ext ? map_e.exists(b) : map_n.exists(b);
      hid = 8'h00;
      if (mapped) hid = m_ext ? map_e[b] : map_n[b];
      nk = m_kc;
      if (mapped) nk = m_brk ? ((m_kc == hid) ? 8'h00 : m_kc) : hid;
      if (nk != m_kc) exp_ks++;
      m_kc = nk;
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  // Per-cycle output checks against the model and pulse bookkeeping.
  always @(negedge Clk) begin
    cyc++;
    if (Reset_n) begin
      if (scan_valid) begin
        sv_cnt++;
        last_sv = cyc;
        if (exp_q.size() == 0) check("unexpected_scan_valid", {24'h0, scan_byte}, 32'hFFFF_FFFF);
        else check("scan_byte", {24'h0, scan_byte}, {24'h0, exp_q.pop_front()});
      end
      if (frame_err) fe_cnt++;
      if (keycode_strobe) begin
        ks_cnt++;
        check("strobe_latency", cyc - last_sv, 1);
      end
      check("strobe_iff_change", {31'h0, keycode_strobe}, {31'h0, keycode != prev_kc});
      if (settled) begin
        check("keycode_model", {24'h0, keycode}, {24'h0, m_kc});
        check("scan_byte_hold", {24'h0, scan_byte}, {24'h0, m_last});
      end
    end
    prev_kc = keycode;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic check_counts();
    check("scan_valid_count", sv_cnt, exp_sv);
    check("frame_err_count", fe_cnt, exp_fe);
    check("strobe_count", ks_cnt, exp_ks);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic p;
    bit good;
    p = ~(^b) ^ bad_par;
    good = !bad_par && !bad_stop;
    settled = 1'b0;
    if (good) exp_q.push_back(b);
    else exp_fe++;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(~bad_stop);
    wait_cyc(8);
    if (good) begin
      exp_sv++;
      m_last = b;
      model_byte(b);
    end
    settled = 1'b1;
    check_counts();
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  int ks0, fe0;

  initial begin
    map_n[8'h5A] = 8'h28; map_n[8'h1D] = 8'h1A; map_n[8'h1C] = 8'h04; map_n[8'h1B] = 8'h16;
    map_n[8'h23] = 8'h07; map_n[8'h29] = 8'h2C; map_n[8'h76] = 8'h29;
    map_e[8'h75] = 8'h52; map_e[8'h72] = 8'h51; map_e[8'h6B] = 8'h50; map_e[8'h74] = 8'h4F;
    map_e[8'h5A] = 8'h28;

    Reset_n = 1'b1;
    #2 Reset_n = 1'b0;
    #1;
    check("rst_keycode", {24'h0, keycode}, 32'h0);
    check("rst_scan_byte", {24'h0, scan_byte}, 32'h0);
    check("rst_pulses", {29'h0, keycode_strobe, scan_valid, frame_err}, 32'h0);
    wait_cyc(5);
    check("rst_hold_keycode", {24'h0, keycode}, 32'h0);
    Reset_n = 1'b1;
    wait_cyc(5);
    settled = 1'b1;

    good(8'h5A);
    check("lit_5a_kc", {24'h0, keycode}, 32'h28);
    check("lit_5a_byte", {24'h0, scan_byte}, 32'h5A);

    ks0 = ks_cnt;
    good(8'hE0); good(8'h75);
    check("lit_e075", {24'h0, keycode}, 32'h52);
    good(8'hE0); good(8'hF0); good(8'h75);
    check("lit_e0f075", {24'h0, keycode}, 32'h00);
    check("lit_ext_strobes", ks_cnt - ks0, 2);

    ks0 = ks_cnt;
    good(8'h1D); good(8'h1C); good(8'hF0); good(8'h1D);
    check("lit_1d1c_kc", {24'h0, keycode}, 32'h04);
    check("lit_1d1c_strobes", ks_cnt - ks0, 2);

    fe0 = fe_cnt;
    send_frame(8'h1D, 1'b1, 1'b0);
    check("lit_badpar_kc", {24'h0, keycode}, 32'h04);
    check("lit_badpar_err", fe_cnt - fe0, 1);
    send_frame(8'h5A, 1'b0, 1'b1);

    settled = 1'b0;
    exp_fe++;
    ps2_bit(1'b1);
    wait_cyc(8);
    settled = 1'b1;
    check_counts();

    ks0 = ks_cnt;
    good(8'h1C);
    check("lit_typematic", ks_cnt - ks0, 0);
    good(8'hAA); good(8'hE1);
    check("lit_unmapped", {24'h0, keycode}, 32'h04);
    good(8'hE0); good(8'h5A);
    check("lit_ext_5a", {24'h0, keycode}, 32'h28);
    good(8'hF0); good(8'h5A);
    check("lit_break_5a", {24'h0, keycode}, 32'h00);
    good(8'h23); good(8'h29); good(8'hF0); good(8'h23);
    check("lit_override", {24'h0, keycode}, 32'h2C);
    good(8'hE0); good(8'hF0); good(8'h29);

    fe0 = fe_cnt;
    settled = 1'b0;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    wait_cyc(TOUT + 40);
    exp_fe++;
    settled = 1'b1;
    check("lit_timeout_err", fe_cnt - fe0, 1);
    good(8'h23);
    check("lit_after_timeout", {24'h0, keycode}, 32'h07);

    settled = 1'b0;
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    ps2_data = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(3);
    Reset_n = 1'b0;
    #1;
    check("lit_midreset_kc", {24'h0, keycode}, 32'h00);
    m_kc = 8'h00; m_last = 8'h00; m_brk = 1'b0; m_ext = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(10);
    Reset_n = 1'b1;
    wait_cyc(5);
    settled = 1'b1;
    good(8'h29);
    check("lit_after_reset", {24'h0, keycode}, 32'h2C);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
